// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave shifter: FSM state encoding,
// default word width and minimum synchroniser depth.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  localparam int SPI_WORD_W   = 8;
  localparam int SPI_MIN_SYNC = 2;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a previous-value flop
// so rising and falling edges of the synchronised level can be detected.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_pin};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end, oversampled in the clk domain: deserialises MOSI,
// serialises the response word on MISO. Optional SPI_SLAVE_FRAME_ERR_EN adds o_frame_err.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_MIN_SYNC,
  parameter int WIDTH       = SPI_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic             o_slave_rdy,
  output logic             o_rx_done,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic             o_frame_err,
`endif
  output logic [WIDTH-1:0] o_mosi_byte,
  input  logic [WIDTH-1:0] i_miso_byte,
  input  logic             i_spi_clk,
  input  logic             i_spi_mosi,
  input  logic             i_spi_cs_n,
  output logic             o_spi_miso
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  spi_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift, r_tx_shift, r_mosi_byte;
  logic             r_rx_done, r_spi_miso;

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_last_bit;
  logic [WIDTH-1:0] w_rx_word;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_pin(i_spi_clk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .i_pin(i_spi_cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_pin(i_spi_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

  assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_rx_word  = {r_rx_shift[WIDTH-2:0], w_mosi};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_frame_err;
  assign o_frame_err = r_frame_err;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_mosi_byte <= '0;
      r_rx_done   <= 1'b0;
      r_spi_miso  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_rx_done <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_spi_miso <= 1'b0;
          if (w_cs_fall) begin
            r_tx_shift <= i_miso_byte;
            r_spi_miso <= i_miso_byte[WIDTH-1];
            r_bit_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            // A word completing on the same cycle as deselect still counts.
            if (w_sclk_rise && w_last_bit) begin
              r_mosi_byte <= w_rx_word;
              r_rx_done   <= 1'b1;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            else if (r_bit_cnt != '0) begin
              r_frame_err <= 1'b1;
            end
`endif
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_spi_miso <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_word;
            if (w_last_bit) begin
              r_mosi_byte <= w_rx_word;
              r_rx_done   <= 1'b1;
              r_bit_cnt   <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end else if (w_sclk_fall) begin
            // Falling edge at count 0 is the word boundary: fetch the next response.
            if (r_bit_cnt != '0) begin
              r_tx_shift <= r_tx_shift << 1;
              r_spi_miso <= r_tx_shift[WIDTH-2];
            end else begin
              r_tx_shift <= i_miso_byte;
              r_spi_miso <= i_miso_byte[WIDTH-1];
            end
          end
        end
        default: r_spi_miso <= 1'b0;
      endcase
    end
  end

  assign o_slave_rdy = (r_state == IDLE);
  assign o_rx_done   = r_rx_done;
  assign o_mosi_byte = r_mosi_byte;
  assign o_spi_miso  = r_spi_miso;

endmodule
